// File: rtl/ppu_pkg.sv
// Shared definitions for the tile sprite renderer: descriptor layout, ROM address
// layout, fetch FSM states and small sizing helpers.
package ppu_pkg;

    localparam int ENT_W          = 18;
    localparam int ENT_RUN_LSB    = 0;
    localparam int ENT_VFLIP_BIT  = 3;
    localparam int ENT_TY_LSB     = 4;
    localparam int ENT_TX_LSB     = 8;
    localparam int ENT_ORIENT_LSB = 12;
    localparam int ENT_ID_LSB     = 14;

    localparam logic [3:0] ID_UNUSED = 4'hF;

    localparam int ROM_ADDR_W      = 9;
    localparam int ROM_ORIENT_LSB  = 0;
    localparam int ROM_ID_LSB      = 2;
    localparam int ROM_LINE_LSB    = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } fsm_state_t;

    // Field order matches the descriptor bit offsets above, MSB first.
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] orient;
        logic [3:0] tile_x;
        logic [3:0] tile_y;
        logic       vflip;
        logic [2:0] run;
    } ent_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [ROM_ADDR_W-1:0] make_rom_addr(input logic [2:0] line,
                                                            input logic [3:0] id,
                                                            input logic [1:0] orient);
        return {line, id, orient};
    endfunction

endpackage

// File: rtl/ppu_cfg_check.sv
// Elaboration-time legality check: a worst-case fetch must fit inside one tile
// and inside the left border.
module ppu_cfg_check #(
    parameter int N_ENT       = 16,
    parameter int TILE_CYCLES = 40,
    parameter int H_OFFSET    = 40
) ();

    if ((N_ENT < 1) || (N_ENT > 32) || (N_ENT + 3 > TILE_CYCLES) || (N_ENT + 3 > H_OFFSET)) begin : g_bad_cfg
        $error("tile_sprite_renderer: N_ENT=%0d cannot complete a fetch within one tile", N_ENT);
    end

endmodule

// File: rtl/ppu_pixel_counters.sv
// One axis of sub-pixel / sprite-pixel / tile counters; exposes the values that
// apply to the sample being presented this cycle.
module ppu_pixel_counters
    import ppu_pkg::*;
#(
    parameter int OFFSET  = 40,
    parameter int UPSCALE = 5,
    parameter int TILE_PX = 8,
    parameter int N_TILES = 16,
    localparam int SUB_W  = idx_w(UPSCALE),
    localparam int COL_W  = idx_w(TILE_PX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [9:0]       pos,
    output logic [COL_W-1:0] col_s,
    output logic [3:0]       tile_s,
    output logic             first_s
);

    logic [SUB_W-1:0] sub_r;
    logic [SUB_W-1:0] sub_s;
    logic [COL_W-1:0] col_r;
    logic [3:0]       tile_r;

    // Next counter values: clear at the offset, otherwise advance on step.
    always_comb begin
        sub_s  = sub_r;
        col_s  = col_r;
        tile_s = tile_r;
        if (step && (pos == 10'(OFFSET))) begin
            sub_s  = '0;
            col_s  = '0;
            tile_s = 4'd0;
        end else if (step) begin
            if (sub_r == SUB_W'(UPSCALE - 1)) begin
                sub_s = '0;
                if (col_r == COL_W'(TILE_PX - 1)) begin
                    col_s  = '0;
                    tile_s = (tile_r == 4'(N_TILES - 1)) ? 4'd0 : tile_r + 4'd1;
                end else begin
                    col_s = col_r + COL_W'(1'b1);
                end
            end else begin
                sub_s = sub_r + SUB_W'(1'b1);
            end
        end else begin
            sub_s = sub_r;
        end
    end

    assign first_s = (sub_s == '0) && (col_s == '0);

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sub_r  <= '0;
            col_r  <= '0;
            tile_r <= 4'd0;
        end else begin
            sub_r  <= sub_s;
            col_r  <= col_s;
            tile_r <= tile_s;
        end
    end

endmodule

// File: rtl/tile_sprite_renderer.sv
// Tile-based sprite renderer: prefetches the next tile's sprite row (priority
// scan over N_ENT slots plus one ROM read), double-buffers it and streams 1-bit colour.
module tile_sprite_renderer
    import ppu_pkg::*;
#(
    parameter int   N_ENT     = 16,
    parameter int   TILE_PX   = 8,
    parameter int   UPSCALE   = 5,
    parameter int   TILES_H   = 16,
    parameter int   TILES_V   = 12,
    parameter int   H_OFFSET  = 40,
    parameter int   V_OFFSET  = 40,
    parameter logic BG_COLOUR = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixel_en,
    input  logic [9:0]             counter_h,
    input  logic [9:0]             counter_v,
    input  logic [ENT_W*N_ENT-1:0] entities,
    output logic [ROM_ADDR_W-1:0]  rom_addr,
    output logic                   rom_en,
    input  logic [TILE_PX-1:0]     rom_data,
    output logic                   colour,
    output logic                   collision
);

    localparam int COL_W  = idx_w(TILE_PX);
    localparam int K_W    = idx_w(N_ENT);
    localparam int H_END  = H_OFFSET + TILES_H * TILE_PX * UPSCALE;
    localparam int V_END  = V_OFFSET + TILES_V * TILE_PX * UPSCALE;

    ppu_cfg_check #(.N_ENT(N_ENT), .TILE_CYCLES(TILE_PX * UPSCALE), .H_OFFSET(H_OFFSET)) u_cfg_check ();

    logic [COL_W-1:0] h_col_s, v_row_s, row_r, line_s;
    logic [3:0]       h_tile_s, v_tile_s;
    logic             h_first_s, v_first_unused_s;

    ppu_pixel_counters #(.OFFSET(H_OFFSET), .UPSCALE(UPSCALE), .TILE_PX(TILE_PX), .N_TILES(TILES_H)) u_h_cnt (
        .clk(clk), .reset(reset), .step(pixel_en), .pos(counter_h),
        .col_s(h_col_s), .tile_s(h_tile_s), .first_s(h_first_s)
    );

    ppu_pixel_counters #(.OFFSET(V_OFFSET), .UPSCALE(UPSCALE), .TILE_PX(TILE_PX), .N_TILES(TILES_V)) u_v_cnt (
        .clk(clk), .reset(reset), .step(pixel_en && (counter_h == 10'd0)), .pos(counter_v),
        .col_s(v_row_s), .tile_s(v_tile_s), .first_s(v_first_unused_s)
    );

    fsm_state_t       state_r;
    logic [K_W-1:0]   k_r;
    logic             hit_r;
    logic [1:0]       hits_r;
    logic [3:0]       tx_r, ty_r;
    logic [3:0]       win_id_r;
    logic [1:0]       win_orient_r;
    logic             win_vflip_r;
    logic             cur_hit_r, nxt_hit_r;
    logic [TILE_PX-1:0] cur_data_r, nxt_data_r;

    logic active_s, tile_start_s, line_start_s, trigger_s, hit_s;
    logic [3:0] trig_tx_s, dx_s, run_eff_s, sel_id_s;
    logic [1:0] sel_orient_s;
    logic       sel_vflip_s;
    ent_t       slot_s;

    assign active_s = (counter_h >= 10'(H_OFFSET)) && (counter_h < 10'(H_END)) &&
                      (counter_v >= 10'(V_OFFSET)) && (counter_v < 10'(V_END));
    assign tile_start_s = pixel_en && active_s && h_first_s;
    assign line_start_s = pixel_en && (counter_h == 10'd0);
    assign trigger_s    = line_start_s || (tile_start_s && (h_tile_s < 4'(TILES_H - 1)));
    assign trig_tx_s    = line_start_s ? 4'd0 : h_tile_s + 4'd1;

    // Slot hit test in 4-bit arithmetic so runs wrap past the right edge.
    assign slot_s    = ent_t'(entities[k_r * ENT_W +: ENT_W]);
    assign dx_s      = tx_r - slot_s.tile_x;
    assign run_eff_s = (slot_s.run == 3'd0) ? 4'd1 : {1'b0, slot_s.run};
    assign hit_s     = (slot_s.id != ID_UNUSED) && (slot_s.tile_y == ty_r) && (dx_s < run_eff_s);

    assign sel_id_s     = hit_r ? win_id_r     : slot_s.id;
    assign sel_orient_s = hit_r ? win_orient_r : slot_s.orient;
    assign sel_vflip_s  = hit_r ? win_vflip_r  : slot_s.vflip;
    assign line_s       = sel_vflip_s ? ~row_r : row_r;

    // Fetch FSM, ROM interface and the two row buffers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            k_r          <= '0;
            hit_r        <= 1'b0;
            hits_r       <= 2'd0;
            tx_r         <= 4'd0;
            ty_r         <= 4'd0;
            row_r        <= '0;
            win_id_r     <= 4'd0;
            win_orient_r <= 2'd0;
            win_vflip_r  <= 1'b0;
            rom_en       <= 1'b0;
            rom_addr     <= 9'h1FF;
            collision    <= 1'b0;
            cur_hit_r    <= 1'b0;
            cur_data_r   <= '0;
            nxt_hit_r    <= 1'b0;
            nxt_data_r   <= '0;
        end else begin
            rom_en    <= 1'b0;
            collision <= 1'b0;
            if (trigger_s) begin
                state_r <= SCAN;
                k_r     <= '0;
                hit_r   <= 1'b0;
                hits_r  <= 2'd0;
                tx_r    <= trig_tx_s;
                ty_r    <= v_tile_s;
                row_r   <= v_row_s;
            end else begin
                case (state_r)
                    IDLE: state_r <= IDLE;
                    SCAN: begin
                        if (hit_s && !hit_r) begin
                            win_id_r     <= slot_s.id;
                            win_orient_r <= slot_s.orient;
                            win_vflip_r  <= slot_s.vflip;
                        end
                        hit_r <= hit_r | hit_s;
                        if (hit_s && (hits_r != 2'd2)) begin
                            hits_r <= hits_r + 2'd1;
                        end
                        if (k_r == K_W'(N_ENT - 1)) begin
                            if (hit_r || hit_s) begin
                                state_r  <= FETCH;
                                rom_en   <= 1'b1;
                                rom_addr <= make_rom_addr(3'(line_s), sel_id_s, sel_orient_s);
                            end else begin
                                state_r <= DONE;
                            end
                        end else begin
                            k_r <= k_r + K_W'(1'b1);
                        end
                    end
                    FETCH: state_r <= WAIT;
                    WAIT: begin
                        nxt_hit_r  <= 1'b1;
                        nxt_data_r <= rom_data;
                        state_r    <= DONE;
                    end
                    DONE: begin
                        collision <= (hits_r == 2'd2);
                        if (!hit_r) begin
                            nxt_hit_r  <= 1'b0;
                            nxt_data_r <= '0;
                        end
                        state_r <= IDLE;
                    end
                    default: state_r <= IDLE;
                endcase
            end
            // Swap last so a fetch still landing at the tile boundary leaves the tile empty.
            if (tile_start_s) begin
                cur_hit_r  <= nxt_hit_r;
                cur_data_r <= nxt_data_r;
                nxt_hit_r  <= 1'b0;
                nxt_data_r <= '0;
            end
        end
    end

    // Colour for the sample presented with pixel_en; the swap cycle reads the incoming buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            colour <= BG_COLOUR;
        end else if (pixel_en) begin
            if (!active_s) begin
                colour <= BG_COLOUR;
            end else if (tile_start_s) begin
                colour <= nxt_hit_r ? nxt_data_r[h_col_s] : BG_COLOUR;
            end else begin
                colour <= cur_hit_r ? cur_data_r[h_col_s] : BG_COLOUR;
            end
        end else begin
            colour <= colour;
        end
    end

endmodule
